// File: rtl/uart_cfg.sv
// rtl/uart_cfg.sv - runtime-configurable UART (5-8 data bits, parity, 1/2 stop)
// with 16x oversampled receiver, first-word-fall-through TX/RX FIFOs and sticky errors.
module uart_cfg #(
   parameter int FIFO_W = 4,
   parameter int DVSR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DVSR_W-1:0] cfg_dvsr,
   input  logic [1:0]        cfg_dbits,
   input  logic [1:0]        cfg_par,
   input  logic              cfg_stop,
   input  logic              rx,
   input  logic              wr_uart,
   input  logic [7:0]        w_data,
   input  logic              rd_uart,
   output logic [7:0]        r_data,
   input  logic              clr_err,
   output logic              tx,
   output logic              tx_full,
   output logic              rx_empty,
   output logic              tx_idle,
   output logic              err_par,
   output logic              err_frame,
   output logic              err_ovr,
   output logic [FIFO_W:0]   rx_level
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   localparam logic [FIFO_W:0]   DEPTH    = {1'b1, {FIFO_W{1'b0}}};
   localparam logic [FIFO_W:0]   CNT_ONE  = {{FIFO_W{1'b0}}, 1'b1};
   localparam logic [FIFO_W-1:0] PTR_ONE  = CNT_ONE[FIFO_W-1:0];
   localparam logic [DVSR_W-1:0] BAUD_ONE = {{(DVSR_W-1){1'b0}}, 1'b1};

   logic [DVSR_W-1:0] baud_q, baud_d;
   logic              tick;
   logic              rx_meta_q, rx_sync_q;

   logic [2:0] rx_st_q, rx_st_d;
   logic [3:0] rx_s_q, rx_s_d;
   logic [2:0] rx_n_q, rx_n_d;
   logic [7:0] rx_b_q, rx_b_d;
   logic [1:0] rx_dbits_q, rx_dbits_d;
   logic [1:0] rx_par_q, rx_par_d;
   logic       rx_acc_q, rx_acc_d;
   logic       rx_perr_q, rx_perr_d;
   logic       rx_done;
   logic [7:0] rx_byte;

   logic [2:0] tx_st_q, tx_st_d;
   logic [4:0] tx_s_q, tx_s_d;
   logic [2:0] tx_n_q, tx_n_d;
   logic [7:0] tx_b_q, tx_b_d;
   logic [1:0] tx_dbits_q, tx_dbits_d;
   logic       tx_pen_q, tx_pen_d;
   logic       tx_pbit_q, tx_pbit_d;
   logic       tx_stop_q, tx_stop_d;
   logic       tx_q, tx_d;
   logic       tx_pop;
   logic [7:0] tx_mask;

   logic [7:0]        tx_mem_q [0:(1<<FIFO_W)-1];
   logic [7:0]        rx_mem_q [0:(1<<FIFO_W)-1];
   logic [FIFO_W-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   logic [FIFO_W-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   logic [FIFO_W:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic              tx_empty, rx_full, tx_push, rx_push, rx_pop;
   logic [7:0]        tx_head;

   logic err_par_q, err_par_d, err_frame_q, err_frame_d, err_ovr_q, err_ovr_d;

   // >= rather than == keeps the counter bounded if cfg_dvsr shrinks mid-count
   always_comb begin
      tick   = (baud_q >= cfg_dvsr);
      baud_d = tick ? '0 : baud_q + BAUD_ONE;
   end

   always_comb begin
      rx_st_d    = rx_st_q;
      rx_s_d     = rx_s_q;
      rx_n_d     = rx_n_q;
      rx_b_d     = rx_b_q;
      rx_dbits_d = rx_dbits_q;
      rx_par_d   = rx_par_q;
      rx_acc_d   = rx_acc_q;
      rx_perr_d  = rx_perr_q;
      rx_done    = 1'b0;
      case (rx_st_q)
         ST_IDLE: if (!rx_sync_q) begin
            rx_st_d    = ST_START;
            rx_s_d     = '0;
            rx_b_d     = '0;
            rx_acc_d   = 1'b0;
            rx_perr_d  = 1'b0;
            rx_dbits_d = cfg_dbits;
            rx_par_d   = cfg_par;
         end
         ST_START: if (tick) begin
            if (rx_s_q == 4'd7) begin
               rx_s_d  = '0;
               rx_n_d  = '0;
               rx_st_d = rx_sync_q ? ST_IDLE : ST_DATA;
            end else rx_s_d = rx_s_q + 4'd1;
         end
         ST_DATA: if (tick) begin
            if (rx_s_q == 4'd15) begin
               rx_s_d   = '0;
               rx_b_d   = {rx_sync_q, rx_b_q[7:1]};
               rx_acc_d = rx_acc_q ^ rx_sync_q;
               if (rx_n_q == {1'b0, rx_dbits_q} + 3'd4)
                  rx_st_d = (^rx_par_q) ? ST_PARITY : ST_STOP;
               else rx_n_d = rx_n_q + 3'd1;
            end else rx_s_d = rx_s_q + 4'd1;
         end
         ST_PARITY: if (tick) begin
            if (rx_s_q == 4'd15) begin
               rx_s_d    = '0;
               rx_perr_d = rx_acc_q ^ rx_sync_q ^ rx_par_q[1];
               rx_st_d   = ST_STOP;
            end else rx_s_d = rx_s_q + 4'd1;
         end
         ST_STOP: if (tick) begin
            if (rx_s_q == 4'd15) begin
               rx_done = 1'b1;
               rx_st_d = ST_IDLE;
            end else rx_s_d = rx_s_q + 4'd1;
         end
         default: rx_st_d = ST_IDLE;
      endcase
   end

   // bits arrive at the MSB end; right-align short words so unused high bits read 0
   assign rx_byte = rx_b_q >> (2'd3 - rx_dbits_q);

   always_comb begin
      tx_st_d    = tx_st_q;
      tx_s_d     = tx_s_q;
      tx_n_d     = tx_n_q;
      tx_b_d     = tx_b_q;
      tx_dbits_d = tx_dbits_q;
      tx_pen_d   = tx_pen_q;
      tx_pbit_d  = tx_pbit_q;
      tx_stop_d  = tx_stop_q;
      tx_pop     = 1'b0;
      tx_mask    = 8'hFF >> (2'd3 - cfg_dbits);
      case (tx_st_q)
         ST_IDLE: if (tick && !tx_empty) begin
            tx_st_d    = ST_START;
            tx_s_d     = '0;
            tx_b_d     = tx_head;
            tx_dbits_d = cfg_dbits;
            tx_pen_d   = ^cfg_par;
            tx_pbit_d  = (^(tx_head & tx_mask)) ^ cfg_par[1];
            tx_stop_d  = cfg_stop;
         end
         ST_START: if (tick) begin
            if (tx_s_q == 5'd15) begin
               tx_s_d  = '0;
               tx_n_d  = '0;
               tx_st_d = ST_DATA;
            end else tx_s_d = tx_s_q + 5'd1;
         end
         ST_DATA: if (tick) begin
            if (tx_s_q == 5'd15) begin
               tx_s_d = '0;
               tx_b_d = {1'b0, tx_b_q[7:1]};
               if (tx_n_q == {1'b0, tx_dbits_q} + 3'd4)
                  tx_st_d = tx_pen_q ? ST_PARITY : ST_STOP;
               else tx_n_d = tx_n_q + 3'd1;
            end else tx_s_d = tx_s_q + 5'd1;
         end
         ST_PARITY: if (tick) begin
            if (tx_s_q == 5'd15) begin
               tx_s_d  = '0;
               tx_st_d = ST_STOP;
            end else tx_s_d = tx_s_q + 5'd1;
         end
         ST_STOP: if (tick) begin
            if (tx_s_q == (tx_stop_q ? 5'd31 : 5'd15)) begin
               tx_pop  = 1'b1;
               tx_st_d = ST_IDLE;
            end else tx_s_d = tx_s_q + 5'd1;
         end
         default: tx_st_d = ST_IDLE;
      endcase
      case (tx_st_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = tx_b_d[0];
         ST_PARITY: tx_d = tx_pbit_d;
         default:   tx_d = 1'b1;
      endcase
   end

   assign tx_empty = (tx_cnt_q == '0);
   assign tx_full  = (tx_cnt_q == DEPTH);
   assign rx_empty = (rx_cnt_q == '0);
   assign rx_full  = (rx_cnt_q == DEPTH);
   assign tx_head  = tx_mem_q[tx_rp_q];

   always_comb begin
      tx_push  = wr_uart && (!tx_full || tx_pop);
      rx_pop   = rd_uart && !rx_empty;
      rx_push  = rx_done && (!rx_full || rx_pop);
      tx_wp_d  = tx_push ? tx_wp_q + PTR_ONE : tx_wp_q;
      tx_rp_d  = tx_pop  ? tx_rp_q + PTR_ONE : tx_rp_q;
      rx_wp_d  = rx_push ? rx_wp_q + PTR_ONE : rx_wp_q;
      rx_rp_d  = rx_pop  ? rx_rp_q + PTR_ONE : rx_rp_q;
      tx_cnt_d = tx_cnt_q;
      if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + CNT_ONE;
      else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CNT_ONE;
      rx_cnt_d = rx_cnt_q;
      if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + CNT_ONE;
      else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CNT_ONE;
      err_par_d   = (err_par_q & ~clr_err) | (rx_done & rx_perr_q);
      err_frame_d = (err_frame_q & ~clr_err) | (rx_done & ~rx_sync_q);
      err_ovr_d   = (err_ovr_q & ~clr_err) | (rx_done & rx_full & ~rx_pop);
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem_q[tx_wp_q] <= w_data;
      if (rx_push) rx_mem_q[rx_wp_q] <= rx_byte;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         baud_q      <= '0;
         rx_meta_q   <= 1'b1;
         rx_sync_q   <= 1'b1;
         rx_st_q     <= ST_IDLE;
         rx_s_q      <= '0;
         rx_n_q      <= '0;
         rx_b_q      <= '0;
         rx_dbits_q  <= '0;
         rx_par_q    <= '0;
         rx_acc_q    <= 1'b0;
         rx_perr_q   <= 1'b0;
         tx_st_q     <= ST_IDLE;
         tx_s_q      <= '0;
         tx_n_q      <= '0;
         tx_b_q      <= '0;
         tx_dbits_q  <= '0;
         tx_pen_q    <= 1'b0;
         tx_pbit_q   <= 1'b0;
         tx_stop_q   <= 1'b0;
         tx_q        <= 1'b1;
         tx_wp_q     <= '0;
         tx_rp_q     <= '0;
         tx_cnt_q    <= '0;
         rx_wp_q     <= '0;
         rx_rp_q     <= '0;
         rx_cnt_q    <= '0;
         err_par_q   <= 1'b0;
         err_frame_q <= 1'b0;
         err_ovr_q   <= 1'b0;
      end else begin
         baud_q      <= baud_d;
         rx_meta_q   <= rx;
         rx_sync_q   <= rx_meta_q;
         rx_st_q     <= rx_st_d;
         rx_s_q      <= rx_s_d;
         rx_n_q      <= rx_n_d;
         rx_b_q      <= rx_b_d;
         rx_dbits_q  <= rx_dbits_d;
         rx_par_q    <= rx_par_d;
         rx_acc_q    <= rx_acc_d;
         rx_perr_q   <= rx_perr_d;
         tx_st_q     <= tx_st_d;
         tx_s_q      <= tx_s_d;
         tx_n_q      <= tx_n_d;
         tx_b_q      <= tx_b_d;
         tx_dbits_q  <= tx_dbits_d;
         tx_pen_q    <= tx_pen_d;
         tx_pbit_q   <= tx_pbit_d;
         tx_stop_q   <= tx_stop_d;
         tx_q        <= tx_d;
         tx_wp_q     <= tx_wp_d;
         tx_rp_q     <= tx_rp_d;
         tx_cnt_q    <= tx_cnt_d;
         rx_wp_q     <= rx_wp_d;
         rx_rp_q     <= rx_rp_d;
         rx_cnt_q    <= rx_cnt_d;
         err_par_q   <= err_par_d;
         err_frame_q <= err_frame_d;
         err_ovr_q   <= err_ovr_d;
      end
   end

   assign tx        = tx_q;
   assign tx_idle   = tx_empty && (tx_st_q == ST_IDLE);
   assign r_data    = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q];
   assign rx_level  = rx_cnt_q;
   assign err_par   = err_par_q;
   assign err_frame = err_frame_q;
   assign err_ovr   = err_ovr_q;

endmodule

// File: tb/tb_uart_cfg.sv
// tb/tb_uart_cfg.sv - directed self-checking bench for uart_cfg (FIFO_W=2, dvsr=3)
module tb_uart_cfg;
   localparam int FW = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] cfg_dvsr;
   logic [1:0]  cfg_dbits, cfg_par;
   logic        cfg_stop;
   logic        rx_drv, loop, rx_line;
   logic        wr_uart, rd_uart, clr_err;
   logic [7:0]  w_data, r_data;
   logic        tx, tx_full, rx_empty, tx_idle, err_par, err_frame, err_ovr;
   logic [FW:0] rx_level;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;
   assign rx_line = loop ? tx : rx_drv;

   uart_cfg #(.FIFO_W(FW), .DVSR_W(16)) dut (
      .clk(clk), .reset(rst_n), .cfg_dvsr(cfg_dvsr), .cfg_dbits(cfg_dbits),
      .cfg_par(cfg_par), .cfg_stop(cfg_stop), .rx(rx_line), .wr_uart(wr_uart),
      .w_data(w_data), .rd_uart(rd_uart), .r_data(r_data), .clr_err(clr_err),
      .tx(tx), .tx_full(tx_full), .rx_empty(rx_empty), .tx_idle(tx_idle),
      .err_par(err_par), .err_frame(err_frame), .err_ovr(err_ovr), .rx_level(rx_level)
   );

   typedef struct {
      logic [1:0] dbits;
      logic [1:0] par;
      logic       stop;
      logic [7:0] data;
      logic       bad_par;
      logic       bad_stop;
      logic [7:0] exp_data;
      logic       exp_perr;
      logic       exp_ferr;
   } rx_vec_t;

   rx_vec_t vecs [9];

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // drives one serial frame on rx_drv at 16 ticks per bit
   task automatic send_frame(input rx_vec_t v);
      int bt, nb;
      logic p;
      logic [7:0] d;
      bt = 16 * (int'(cfg_dvsr) + 1);
      nb = 5 + int'(v.dbits);
      cfg_dbits = v.dbits;
      cfg_par   = v.par;
      cfg_stop  = v.stop;
      d = v.data;
      p = 1'b0;
      rx_drv = 1'b0;
      wait_clks(bt);
      for (int i = 0; i < nb; i++) begin
         rx_drv = d[i];
         p = p ^ d[i];
         wait_clks(bt);
      end
      if (v.par == 2'b01 || v.par == 2'b10) begin
         rx_drv = p ^ (v.par == 2'b10) ^ v.bad_par;
         wait_clks(bt);
      end
      if (v.bad_stop) begin
         rx_drv = 1'b0;
         wait_clks(bt * 3 / 4);
         rx_drv = 1'b1;
         wait_clks(bt / 4);
      end else begin
         rx_drv = 1'b1;
         wait_clks(v.stop ? 2 * bt : bt);
      end
      wait_clks(bt);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, m, lows;
      logic [7:0] exp_b;
      logic [7:0] ov [5];
      rx_vec_t ovv;

      vecs[0] = '{2'b11, 2'b00, 1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{2'b00, 2'b00, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h1F, 1'b0, 1'b0};
      vecs[2] = '{2'b11, 2'b01, 1'b0, 8'h0F, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b0};
      vecs[3] = '{2'b10, 2'b10, 1'b1, 8'h35, 1'b0, 1'b0, 8'h35, 1'b0, 1'b0};
      vecs[4] = '{2'b01, 2'b01, 1'b0, 8'h2A, 1'b0, 1'b0, 8'h2A, 1'b0, 1'b0};
      vecs[5] = '{2'b11, 2'b00, 1'b0, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
      vecs[6] = '{2'b10, 2'b01, 1'b0, 8'hC1, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0};
      vecs[7] = '{2'b01, 2'b10, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h3F, 1'b1, 1'b0};
      vecs[8] = '{2'b11, 2'b11, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0};
      ov[0] = 8'h11; ov[1] = 8'h22; ov[2] = 8'h33; ov[3] = 8'h44; ov[4] = 8'h55;

      rst_n = 1'b0; cfg_dvsr = 16'd3; cfg_dbits = 2'b11; cfg_par = 2'b00; cfg_stop = 1'b0;
      rx_drv = 1'b1; loop = 1'b0; wr_uart = 1'b0; w_data = 8'h00; rd_uart = 1'b0; clr_err = 1'b0;
      wait_clks(3);
      chk1("rst_tx", tx, 1'b1);
      chk1("rst_tx_full", tx_full, 1'b0);
      chk1("rst_rx_empty", rx_empty, 1'b1);
      chk1("rst_tx_idle", tx_idle, 1'b1);
      chk1("rst_errs", err_par | err_frame | err_ovr, 1'b0);
      chki("rst_rx_level", int'(rx_level), 0);
      chk8("rst_r_data", r_data, 8'h00);
      rst_n = 1'b1;
      wait_clks(2);

      // 8N1 0xA5 at dvsr=3: 64 clocks per bit
      w_data = 8'hA5; wr_uart = 1'b1;
      @(negedge clk); wr_uart = 1'b0;
      chk1("a5_busy", tx_idle, 1'b0);
      n = 0;
      while (tx === 1'b1 && n < 200) begin @(negedge clk); n++; end
      chk1("a5_start_seen", tx, 1'b0);
      n = 0;
      while (tx === 1'b0 && n < 200) begin @(negedge clk); n++; end
      chki("a5_start_len", n, 64);
      exp_b = 8'hA5;
      wait_clks(32);
      for (int i = 0; i < 8; i++) begin
         chk1($sformatf("a5_bit%0d", i), tx, exp_b[i]);
         wait_clks(64);
      end
      chk1("a5_stop", tx, 1'b1);
      n = 0;
      while (!tx_idle && n < 200) begin @(negedge clk); n++; end
      chki("a5_idle_at_stop_end", n, 32);
      chk1("a5_tx_high", tx, 1'b1);

      // loopback 7O2
      cfg_dbits = 2'b10; cfg_par = 2'b10; cfg_stop = 1'b1; loop = 1'b1;
      w_data = 8'h35; wr_uart = 1'b1;
      @(negedge clk); wr_uart = 1'b0;
      n = 0;
      while (rx_empty && n < 3000) begin @(negedge clk); n++; end
      chk8("lb_data", r_data, 8'h35);
      chki("lb_level", int'(rx_level), 1);
      chk1("lb_errs", err_par | err_frame | err_ovr, 1'b0);
      n = 0;
      while (!tx_idle && n < 3000) begin @(negedge clk); n++; end
      chk1("lb_tx_idle", tx_idle, 1'b1);
      loop = 1'b0;
      rd_uart = 1'b1;
      @(negedge clk); rd_uart = 1'b0;
      chk1("lb_popped", rx_empty, 1'b1);

      for (int k = 0; k < 9; k++) begin
         send_frame(vecs[k]);
         chk1($sformatf("v%0d_nonempty", k), rx_empty, 1'b0);
         chk8($sformatf("v%0d_data", k), r_data, vecs[k].exp_data);
         chk1($sformatf("v%0d_err_par", k), err_par, vecs[k].exp_perr);
         chk1($sformatf("v%0d_err_frame", k), err_frame, vecs[k].exp_ferr);
         chki($sformatf("v%0d_level", k), int'(rx_level), 1);
         rd_uart = 1'b1; clr_err = 1'b1;
         @(negedge clk); rd_uart = 1'b0; clr_err = 1'b0;
         @(negedge clk);
         chk1($sformatf("v%0d_empty_after_pop", k), rx_empty, 1'b1);
         chk1($sformatf("v%0d_errs_cleared", k), err_par | err_frame, 1'b0);
      end

      // clr_err held through a parity-error event: the event must win
      clr_err = 1'b1;
      fork
         send_frame(vecs[2]);
         begin
            m = 0;
            while (rx_empty && m < 3000) begin @(negedge clk); m++; end
            chk1("clr_race_set", err_par, 1'b1);
            clr_err = 1'b0;
         end
      join
      chk1("clr_race_held", err_par, 1'b1);
      rd_uart = 1'b1; clr_err = 1'b1;
      @(negedge clk); rd_uart = 1'b0; clr_err = 1'b0;

      // 4-tick low glitch is rejected
      rx_drv = 1'b0;
      wait_clks(16);
      rx_drv = 1'b1;
      wait_clks(128);
      chk1("glitch_empty", rx_empty, 1'b1);
      chki("glitch_level", int'(rx_level), 0);

      // overrun on a 4-deep RX FIFO
      for (int k = 0; k < 5; k++) begin
         ovv = vecs[0];
         ovv.data = ov[k];
         send_frame(ovv);
         if (k == 3) begin
            chki("ovr_level_full", int'(rx_level), 4);
            chk1("ovr_not_yet", err_ovr, 1'b0);
         end
      end
      chki("ovr_level", int'(rx_level), 4);
      chk1("ovr_flag", err_ovr, 1'b1);
      for (int k = 0; k < 4; k++) begin
         chk8($sformatf("ovr_read%0d", k), r_data, ov[k]);
         rd_uart = 1'b1;
         @(negedge clk); rd_uart = 1'b0;
      end
      chk1("ovr_drained", rx_empty, 1'b1);
      clr_err = 1'b1;
      @(negedge clk); clr_err = 1'b0;
      chk1("ovr_cleared", err_ovr, 1'b0);

      // reset in the middle of byte 3 of 4
      cfg_dbits = 2'b11; cfg_par = 2'b00; cfg_stop = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         w_data = 8'(k); wr_uart = 1'b1;
         @(negedge clk);
      end
      wr_uart = 1'b0;
      chk1("rst_seq_full", tx_full, 1'b1);
      n = 0;
      while (tx === 1'b1 && n < 200) begin @(negedge clk); n++; end
      wait_clks(1588);
      n = 0;
      while (tx === 1'b1 && n < 700) begin @(negedge clk); n++; end
      chk1("rst_seq_tx_low", tx, 1'b0);
      chk1("rst_seq_busy", tx_idle, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk1("rst_seq_tx_high", tx, 1'b1);
      chk1("rst_seq_tx_idle", tx_idle, 1'b1);
      chk1("rst_seq_tx_full", tx_full, 1'b0);
      wait_clks(3);
      rst_n = 1'b1;
      lows = 0;
      repeat (2000) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      chki("rst_seq_no_more_tx", lows, 0);
      chk1("rst_seq_still_idle", tx_idle, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
